interrupt_cmd_sequencer: RTL and testbench

- Synthesizable stage directly downstream of the testbench's DPI interrupt driver. It consumes chunk-write commands (chunk index, lower 32 bits, upper 32 bits) and drives the core's global interrupt vector.
- Each command carries two counters: a programmable delay before it applies, and an optional hold time after which the chunk auto-clears. Directed tests can therefore place interrupt edges at exact cycles.
- Commands are buffered in a small FIFO and applied strictly in order.

---
 rtl/interrupt_cmd_pkg.sv | 27 ++
 rtl/interrupt_cmd_fifo.sv | 51 +++++
 rtl/interrupt_cmd_sequencer.sv | 153 +++++++++++++++
 tb/tb_interrupt_cmd_sequencer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/interrupt_cmd_pkg.sv
// Shared types for the interrupt command sequencer: the queued command record,
// the sequencer FSM states and the chunk-count helper.
package interrupt_cmd_pkg;

   localparam int CMD_IDX_W = 8;
   localparam int CMD_CNT_W = 16;
   localparam int CHUNK_W   = 64;

   typedef struct packed {
      logic [CMD_IDX_W-1:0] index;
      logic [31:0]          lower;
      logic [31:0]          upper;
      logic [CMD_CNT_W-1:0] delay;
      logic [CMD_CNT_W-1:0] hold;
   } cmd_t;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      HOLD
   } state_e;

   function automatic int num_chunks(input int n_ints);
      return (n_ints + CHUNK_W - 1) / CHUNK_W;
   endfunction

endpackage

// File: rtl/interrupt_cmd_fifo.sv
// Synchronous, non-fall-through command FIFO with flush. Binary pointers carry
// one extra MSB so full and empty are distinguishable without a counter.
module interrupt_cmd_fifo
   import interrupt_cmd_pkg::*;
#(
   parameter type T     = cmd_t,
   parameter int  DEPTH = 4,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        flush_i,
   input  logic        push_i,
   input  T            data_i,
   input  logic        pop_i,
   output T            data_o,
   output logic        full_o,
   output logic        empty_o,
   output logic [AW:0] level_o
);

   logic [AW:0] wr_q, rd_q;
   T            mem_q [DEPTH];
   logic        do_push, do_pop;

   // Flush wins over both push and pop on the same edge.
   assign do_push = push_i && !full_o  && !flush_i;
   assign do_pop  = pop_i  && !empty_o && !flush_i;

   always_ff @(posedge clock) begin
      if (reset || flush_i) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         // NOTE: registers take non-blocking '<=' so every flop samples the pre-edge values.
         if (do_push) wr_q <= wr_q + (AW+1)'(1);
         if (do_pop)  rd_q <= rd_q + (AW+1)'(1);
      end
   end

   // NOTE: storage is deliberately not reset; the pointers alone decide which entries are valid.
   always_ff @(posedge clock) begin
      if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
   end

   assign data_o  = mem_q[rd_q[AW-1:0]];
   assign empty_o = (wr_q == rd_q);
   assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign level_o = wr_q - rd_q;

endmodule

// File: rtl/interrupt_cmd_sequencer.sv
// Applies queued chunk-write commands to the core interrupt vector in order,
// each after a programmable delay and optionally auto-cleared after a hold time.
module interrupt_cmd_sequencer
   import interrupt_cmd_pkg::*;
#(
   parameter  int N_INTS     = 127,
   parameter  int FIFO_DEPTH = 4,
   parameter  int IDX_W      = CMD_IDX_W,
   parameter  int CNT_W      = CMD_CNT_W,
   localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [IDX_W-1:0]  cmd_index,
   input  logic [31:0]       cmd_lower,
   input  logic [31:0]       cmd_upper,
   input  logic [CNT_W-1:0]  cmd_delay,
   input  logic [CNT_W-1:0]  cmd_hold,
   input  logic              clear_all,
   output logic [N_INTS-1:0] interrupts,
   output logic              busy,
   output logic              err_oob,
   output logic [LVL_W-1:0]  fifo_level
);

   localparam int NUM_CHUNKS = num_chunks(N_INTS);

   cmd_t cmd_in, head;
   logic fifo_full, fifo_empty, pop;

   state_e                 state_q, state_d;
   logic [CMD_CNT_W-1:0]   cnt_q, cnt_d;
   logic [CMD_IDX_W-1:0]   idx_q, idx_d;
   logic [CHUNK_W-1:0]     val_q, val_d;
   logic [CMD_CNT_W-1:0]   hold_q, hold_d;
   logic [N_INTS-1:0]      irq_q, irq_d;
   logic                   err_q, err_d;
   logic                   wr_en;
   logic [CHUNK_W-1:0]     wr_val;

   assign cmd_in = '{index: cmd_index, lower: cmd_lower, upper: cmd_upper,
                     delay: cmd_delay, hold: cmd_hold};

   interrupt_cmd_fifo #(.T(cmd_t), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .flush_i (clear_all),
      .push_i  (cmd_valid),
      .data_i  (cmd_in),
      .pop_i   (pop),
      .data_o  (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (fifo_level)
   );

   always_comb begin
      // NOTE: combinational logic uses blocking '=' with every output defaulted first, so no latch is inferred.
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      val_d   = val_q;
      hold_d  = hold_q;
      err_d   = 1'b0;
      pop     = 1'b0;
      wr_en   = 1'b0;
      wr_val  = '0;

      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               pop = 1'b1;
               if (int'(head.index) >= NUM_CHUNKS) begin
                  err_d = 1'b1;
               end else begin
                  idx_d   = head.index;
                  val_d   = {head.upper, head.lower};
                  hold_d  = head.hold;
                  cnt_d   = head.delay;
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CMD_CNT_W'(1);
            end else begin
               wr_en  = 1'b1;
               wr_val = val_q;
               if (hold_q == '0) begin
                  state_d = IDLE;
               end else begin
                  cnt_d   = hold_q;
                  state_d = HOLD;
               end
            end
         end
         HOLD: begin
            if (cnt_q != CMD_CNT_W'(1)) begin
               cnt_d = cnt_q - CMD_CNT_W'(1);
            end else begin
               wr_en   = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Whole-chunk replace; bits of the last chunk beyond N_INTS simply have no target.
      irq_d = irq_q;
      if (wr_en) begin
         for (int i = 0; i < N_INTS; i++) begin
            if (i / CHUNK_W == int'(idx_q)) irq_d[i] = wr_val[i % CHUNK_W];
         end
      end

      if (clear_all) begin
         irq_d   = '0;
         state_d = IDLE;
         cnt_d   = '0;
         err_d   = 1'b0;
         pop     = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         val_q   <= '0;
         hold_q  <= '0;
         irq_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         val_q   <= val_d;
         hold_q  <= hold_d;
         irq_q   <= irq_d;
         err_q   <= err_d;
      end
   end

   assign interrupts = irq_q;
   assign err_oob    = err_q;
   assign cmd_ready  = !fifo_full;
   assign busy       = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_interrupt_cmd_sequencer.sv
// Directed bench for interrupt_cmd_sequencer: a vector table for single commands
// plus hand-written sequences for out-of-range, full FIFO, clear_all and reset.
module tb_interrupt_cmd_sequencer;

   localparam int N_INTS = 127;
   localparam int LVL_W  = 3;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              cmd_valid = 1'b0;
   logic              clear_all = 1'b0;
   logic [7:0]        cmd_index = '0;
   logic [31:0]       cmd_lower = '0;
   logic [31:0]       cmd_upper = '0;
   logic [15:0]       cmd_delay = '0;
   logic [15:0]       cmd_hold  = '0;
   logic              cmd_ready, busy, err_oob;
   logic [N_INTS-1:0] interrupts;
   logic [LVL_W-1:0]  fifo_level;

   int errors = 0;
   int checks = 0;

   interrupt_cmd_sequencer dut (
      .clock      (clock),
      .reset      (reset),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_index  (cmd_index),
      .cmd_lower  (cmd_lower),
      .cmd_upper  (cmd_upper),
      .cmd_delay  (cmd_delay),
      .cmd_hold   (cmd_hold),
      .clear_all  (clear_all),
      .interrupts (interrupts),
      .busy       (busy),
      .err_oob    (err_oob),
      .fifo_level (fifo_level)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [7:0]        idx;
      logic [31:0]       lower;
      logic [31:0]       upper;
      logic [15:0]       delay;
      logic [15:0]       hold;
      logic [N_INTS-1:0] exp_on;
      logic [N_INTS-1:0] exp_off;
   } vec_t;

   vec_t vecs [5];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic set_cmd(input logic [7:0] idx, input logic [31:0] lo, input logic [31:0] up,
                          input logic [15:0] dly, input logic [15:0] hld);
      cmd_index = idx;
      cmd_lower = lo;
      cmd_upper = up;
      cmd_delay = dly;
      cmd_hold  = hld;
   endtask

   task automatic push(input logic [7:0] idx, input logic [31:0] lo, input logic [31:0] up,
                       input logic [15:0] dly, input logic [15:0] hld);
      set_cmd(idx, lo, up, dly, hld);
      cmd_valid = 1'b1;
      tick(1);
      cmd_valid = 1'b0;
   endtask

   function automatic logic [N_INTS-1:0] set_chunk(input logic [N_INTS-1:0] v, input int idx,
                                                   input logic [63:0] val);
      logic [127:0] w;
      w = {1'b0, v};
      w[idx*64 +: 64] = val;
      return w[N_INTS-1:0];
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [N_INTS-1:0] running;
      logic [N_INTS-1:0] fexp [5];
      logic [7:0]        fidx [6];
      logic [31:0]       flo  [6];
      int                lvl_exp [6];
      int                rdy_exp [6];
      vec_t              v;
      int                n;

      vecs[0] = '{idx: 8'd0, lower: 32'h1, upper: 32'h0, delay: 16'd0, hold: 16'd0,
                  exp_on: {63'h0, 64'h1}, exp_off: {63'h0, 64'h1}};
      vecs[1] = '{idx: 8'd1, lower: 32'hF, upper: 32'h0, delay: 16'd5, hold: 16'd0,
                  exp_on: {63'hF, 64'h1}, exp_off: {63'hF, 64'h1}};
      vecs[2] = '{idx: 8'd0, lower: 32'h0, upper: 32'h8000_0000, delay: 16'd0, hold: 16'd3,
                  exp_on: {63'hF, 64'h8000_0000_0000_0000}, exp_off: {63'hF, 64'h0}};
      vecs[3] = '{idx: 8'd1, lower: 32'h1234_5670, upper: 32'hFFFF_FFFF, delay: 16'd2, hold: 16'd0,
                  exp_on: {63'h7FFF_FFFF_1234_5670, 64'h0}, exp_off: {63'h7FFF_FFFF_1234_5670, 64'h0}};
      vecs[4] = '{idx: 8'd0, lower: 32'hA5A5_A5A5, upper: 32'h5A5A_5A5A, delay: 16'd1, hold: 16'd2,
                  exp_on: {63'h7FFF_FFFF_1234_5670, 64'h5A5A_5A5A_A5A5_A5A5},
                  exp_off: {63'h7FFF_FFFF_1234_5670, 64'h0}};

      // Reset state.
      tick(2);
      check("reset_interrupts", interrupts, '0);
      check("reset_level", fifo_level, 0);
      check("reset_ready", cmd_ready, 1);
      check("reset_busy", busy, 0);
      check("reset_err", err_oob, 0);
      reset = 1'b0;
      tick(1);

      // Single commands: unchanged at delay+1, applied at delay+2, cleared after hold.
      running = '0;
      for (int k = 0; k < 5; k++) begin
         v = vecs[k];
         push(v.idx, v.lower, v.upper, v.delay, v.hold);
         check($sformatf("vec%0d_busy_after_push", k), busy, 1);
         tick(int'(v.delay) + 1);
         check($sformatf("vec%0d_before_apply", k), interrupts, running);
         tick(1);
         check($sformatf("vec%0d_apply", k), interrupts, v.exp_on);
         if (v.hold != 0) begin
            if (v.hold > 1) tick(int'(v.hold) - 1);
            check($sformatf("vec%0d_hold_last", k), interrupts, v.exp_on);
            tick(1);
            check($sformatf("vec%0d_hold_clear", k), interrupts, v.exp_off);
         end
         tick(1);
         check($sformatf("vec%0d_idle", k), busy, 0);
         running = v.exp_off;
      end

      // Out-of-range index is dropped with a single err_oob pulse.
      push(8'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'd0, 16'd0);
      check("oob_err_before_pop", err_oob, 0);
      tick(1);
      check("oob_err_pulse", err_oob, 1);
      check("oob_interrupts", interrupts, running);
      tick(1);
      check("oob_err_single", err_oob, 0);
      check("oob_busy", busy, 0);
      check("oob_interrupts_after", interrupts, running);

      // Fill the FIFO: first command goes to the FSM, next four fill it, the sixth is refused.
      fidx = '{8'd0, 8'd1, 8'd0, 8'd1, 8'd0, 8'd1};
      flo  = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h66};
      lvl_exp = '{1, 1, 2, 3, 4, 4};
      rdy_exp = '{1, 1, 1, 1, 0, 0};
      for (int i = 0; i < 5; i++) begin
         fexp[i] = set_chunk((i == 0) ? running : fexp[i-1], int'(fidx[i]), {32'h0, flo[i]});
      end
      for (int i = 0; i < 6; i++) begin
         set_cmd(fidx[i], flo[i], 32'h0, 16'd10, 16'd0);
         cmd_valid = 1'b1;
         tick(1);
         check($sformatf("fill%0d_level", i), fifo_level, lvl_exp[i]);
         check($sformatf("fill%0d_ready", i), cmd_ready, rdy_exp[i]);
      end
      cmd_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         n = 0;
         while (interrupts === ((k == 0) ? running : fexp[k-1]) && n < 40) begin
            tick(1);
            n++;
         end
         check($sformatf("order%0d", k), interrupts, fexp[k]);
      end
      n = 0;
      while (busy && n < 40) begin
         tick(1);
         n++;
      end
      check("fill_drain_busy", busy, 0);
      check("fill_final", interrupts, fexp[4]);
      running = fexp[4];

      // clear_all during HOLD with two queued commands and a simultaneous push.
      push(8'd0, 32'hFF, 32'h0, 16'd0, 16'd10);
      push(8'd1, 32'h1, 32'h0, 16'd0, 16'd0);
      push(8'd1, 32'h2, 32'h0, 16'd0, 16'd0);
      check("clr_pre_level", fifo_level, 2);
      check("clr_pre_interrupts", interrupts, set_chunk(running, 0, 64'hFF));
      set_cmd(8'd1, 32'h77, 32'h0, 16'd0, 16'd0);
      cmd_valid = 1'b1;
      clear_all = 1'b1;
      tick(1);
      cmd_valid = 1'b0;
      clear_all = 1'b0;
      check("clr_interrupts", interrupts, '0);
      check("clr_level", fifo_level, 0);
      check("clr_busy", busy, 0);
      check("clr_ready", cmd_ready, 1);
      tick(20);
      check("clr_later_interrupts", interrupts, '0);
      check("clr_later_busy", busy, 0);

      // Reset while a long delay is counting.
      push(8'd1, 32'h3, 32'h0, 16'd20, 16'd0);
      tick(5);
      check("rst_busy_before", busy, 1);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      check("rst_interrupts", interrupts, '0);
      check("rst_level", fifo_level, 0);
      check("rst_ready", cmd_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_err", err_oob, 0);
      tick(30);
      check("rst_no_apply", interrupts, '0);
      check("rst_still_idle", busy, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
